// File: rtl/rom_pic_reader.sv
// rom_pic_reader: video-side fetch stage for a single-port picture ROM.
// Tracks the pixel position from raw vs/hs/de timing and issues ROM addresses
// for a PIC_W x PIC_H window placed at (X_OFF, Y_OFF). The ROM read data is
// re-aligned with the timing, delayed by L = ROM_LAT+2 cycles, and emitted
// as RGB888. Pixels outside the window are driven as BG_COLOR.
//
// Ports:
//   clk, rst_n          pixel clock, synchronous active-low reset
//   vs_in, hs_in, de_in raw timing (vs active level = VS_POL)
//   rom_addr            registered ROM address
//   rom_clk_en          registered; high while rom_addr carries a new address
//   rom_rd_data         ROM word, valid ROM_LAT cycles after rom_addr
//   vs_out, hs_out,     timing delayed by L cycles
//   de_out
//   rgb_out             {R,G,B} aligned with de_out, 0 while de_out is low
module rom_pic_reader #(
    parameter int unsigned PIC_W    = 256,
    parameter int unsigned PIC_H    = 256,
    parameter int unsigned X_OFF    = 0,
    parameter int unsigned Y_OFF    = 0,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ROM_LAT  = 2,
    parameter logic        VS_POL   = 1'b1,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_clk_en,
    input  logic [DATA_W-1:0] rom_rd_data,
    output logic              vs_out,
    output logic              hs_out,
    output logic              de_out,
    output logic [23:0]       rgb_out
);

    localparam int unsigned LAT       = ROM_LAT + 2;
    localparam int unsigned NSTG      = LAT - 1;
    localparam int unsigned LAST_ADDR = PIC_W * PIC_H - 1;

    logic              vs_prev;
    logic              de_prev;
    logic              synced;
    logic [15:0]       x_cnt;
    logic [15:0]       y_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] line_base;

    logic              vs_edge_c;
    logic              de_fall_c;
    logic [31:0]       x_rel_c;
    logic [31:0]       y_rel_c;
    logic              in_x_c;
    logic              in_y_c;
    logic              in_win_c;
    logic [31:0]       next_base_c;
    logic [23:0]       rgb_exp_c;

    // {vs, hs, de, in_win} per stage; index 0 is stage 1
    logic [3:0]        dly [NSTG];
    logic [3:0]        tap_c;

    assign vs_edge_c = (vs_in == VS_POL) && (vs_prev != VS_POL);
    assign de_fall_c = de_prev & ~de_in;

    // Offset-relative coordinates: positions left of/above the window wrap
    // to huge values, so a single "< size" test covers both bounds.
    assign x_rel_c  = 32'(x_cnt) - 32'(X_OFF);
    assign y_rel_c  = 32'(y_cnt) - 32'(Y_OFF);
    assign in_x_c   = x_rel_c < 32'(PIC_W);
    assign in_y_c   = y_rel_c < 32'(PIC_H);
    assign in_win_c = synced & de_in & in_x_c & in_y_c;

    assign next_base_c = 32'(line_base) + 32'(PIC_W);

    // Position counters, frame sync and address counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_prev   <= ~VS_POL;
            de_prev   <= 1'b0;
            synced    <= 1'b0;
            x_cnt     <= 16'd0;
            y_cnt     <= 16'd0;
            addr_cnt  <= '0;
            line_base <= '0;
        end else begin
            vs_prev <= vs_in;
            de_prev <= de_in;
            if (vs_edge_c) begin
                synced    <= 1'b1;
                x_cnt     <= 16'd0;
                y_cnt     <= 16'd0;
                addr_cnt  <= '0;
                line_base <= '0;
            end else begin
                x_cnt <= de_in ? x_cnt + 16'd1 : 16'd0;
                if (de_fall_c && (y_cnt != 16'hFFFF)) begin
                    y_cnt <= y_cnt + 16'd1;
                end
                // Hold at the last picture word instead of running past it
                if (in_win_c && (addr_cnt != ADDR_W'(LAST_ADDR))) begin
                    addr_cnt <= addr_cnt + ADDR_W'(1);
                end
                // Re-base each row so horizontal clipping never skews rows;
                // no advance past the last row keeps addr_cnt in range.
                if (de_fall_c && in_y_c && (next_base_c <= 32'(LAST_ADDR))) begin
                    line_base <= ADDR_W'(next_base_c);
                    addr_cnt  <= ADDR_W'(next_base_c);
                end
            end
        end
    end

    // ROM address port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr   <= '0;
            rom_clk_en <= 1'b0;
        end else begin
            rom_clk_en <= in_win_c;
            if (in_win_c) begin
                rom_addr <= addr_cnt;
            end
        end
    end

    // Timing / window delay line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NSTG; i++) begin
                dly[i] <= {~VS_POL, 3'b000};
            end
        end else begin
            dly[0] <= {vs_in, hs_in, de_in, in_win_c};
            for (int unsigned i = 1; i < NSTG; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign tap_c = dly[NSTG-1];

    // Pixel format expansion
    generate
        if (DATA_W == 24) begin : g_rgb888
            assign rgb_exp_c = 24'(rom_rd_data);
        end else begin : g_rgb565
            logic [15:0] d565;
            assign d565      = 16'(rom_rd_data);
            // Replicate MSBs into the LSBs so full-scale maps to 8'hFF
            assign rgb_exp_c = {d565[15:11], d565[15:13],
                                d565[10:5],  d565[10:9],
                                d565[4:0],   d565[4:2]};
        end
    endgenerate

    // Output register, final stage of the delay line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_out  <= ~VS_POL;
            hs_out  <= 1'b0;
            de_out  <= 1'b0;
            rgb_out <= 24'h000000;
        end else begin
            vs_out <= tap_c[3];
            hs_out <= tap_c[2];
            de_out <= tap_c[1];
            if (!tap_c[1]) begin
                rgb_out <= 24'h000000;
            end else if (tap_c[0]) begin
                rgb_out <= rgb_exp_c;
            end else begin
                rgb_out <= BG_COLOR;
            end
        end
    end

endmodule
